// File: rtl/neuron_mac_requant_pkg.sv
// Shared widths, saturation limits and FSM state type for the neuron MAC/requantise stage.
package neuron_mac_requant_pkg;

    localparam int DW = 16;
    localparam int AW = 36;
    localparam int SW = 5;

    localparam int SAT_MAX = 32767;
    localparam int SAT_MIN = -32768;

    typedef enum logic [1:0] {
        ACC,
        DRAIN,
        REQ,
        OUT
    } state_e;

endpackage

// File: rtl/neuron_mac_requant_if.sv
// Operand stream, per-vector configuration and result handshake of the neuron MAC stage.
interface neuron_mac_requant_if;
    import neuron_mac_requant_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_a;
    logic signed [DW-1:0] in_b;
    logic                 in_last;
    logic signed [AW-1:0] cfg_bias;
    logic        [SW-1:0] cfg_shift;
    logic                 cfg_relu;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_data;
    logic                 out_sat;

    modport slave (
        input  in_valid, in_a, in_b, in_last, cfg_bias, cfg_shift, cfg_relu, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );

    modport master (
        output in_valid, in_a, in_b, in_last, cfg_bias, cfg_shift, cfg_relu, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

endinterface

// File: rtl/neuron_mac_requant_sat.sv
// Combinational requantiser: bias add, round-half-up, arithmetic shift, saturate and optional ReLU.
module mac_requant_sat
    import neuron_mac_requant_pkg::*;
(
    input  logic signed [AW-1:0] acc_i,
    input  logic signed [AW-1:0] bias_i,
    input  logic        [SW-1:0] shift_i,
    input  logic                 relu_i,
    output logic signed [DW-1:0] data_o,
    output logic                 sat_o
);

    localparam logic signed [AW:0] MaxW = (AW+1)'(SAT_MAX);
    localparam logic signed [AW:0] MinW = (AW+1)'(SAT_MIN);

    logic signed [AW:0] sum;
    logic signed [AW:0] roundInc;
    logic signed [AW:0] rounded;
    logic signed [AW:0] shifted;

    // One extra bit of headroom keeps acc + bias + rounding from wrapping.
    always_comb begin
        sum      = {acc_i[AW-1], acc_i} + {bias_i[AW-1], bias_i};
        roundInc = '0;
        if (shift_i != '0) begin
            roundInc = (AW+1)'(1) << (shift_i - SW'(1));
        end
        rounded = sum + roundInc;
        shifted = rounded >>> shift_i;

        data_o = shifted[DW-1:0];
        sat_o  = 1'b0;
        if (shifted > MaxW) begin
            data_o = DW'(SAT_MAX);
            sat_o  = 1'b1;
        end else if (shifted < MinW) begin
            data_o = DW'(SAT_MIN);
            sat_o  = 1'b1;
        end

        if (relu_i && data_o[DW-1]) begin
            data_o = '0;
        end
    end

endmodule

// File: rtl/neuron_mac_requant.sv
// Neuron output stage: multiply-accumulate a vector of operand pairs, then requantise to DW bits.
module neuron_mac_requant
    import neuron_mac_requant_pkg::*;
(
    input logic             clk,
    input logic             rst,
    neuron_mac_requant_if.slave bus
);

    state_e               state_q, state_d;
    logic           [1:0] drainCnt_q, drainCnt_d;
    logic                 inReady;
    logic                 outValid;
    logic                 accept;

    logic signed [2*DW-1:0] product;
    logic signed [AW-1:0]   prod_q;
    logic                   prodValid_q;
    logic signed [AW-1:0]   acc_q;
    logic                   firstBeat_q;
    logic signed [AW-1:0]   bias_q;
    logic        [SW-1:0]   shift_q;
    logic                   relu_q;
    logic signed [DW-1:0]   outData_q;
    logic                   outSat_q;
    logic signed [DW-1:0]   satData;
    logic                   satFlag;

    assign accept  = bus.in_valid && (state_q == ACC);
    assign product = bus.in_a * bus.in_b;

    // DRAIN holds three cycles so the last product lands and out_valid rises 4 edges after in_last.
    always_comb begin
        state_d    = state_q;
        drainCnt_d = drainCnt_q;
        inReady    = 1'b0;
        outValid   = 1'b0;
        unique case (state_q)
            ACC: begin
                inReady = 1'b1;
                if (accept && bus.in_last) begin
                    state_d    = DRAIN;
                    drainCnt_d = '0;
                end
            end
            DRAIN: begin
                drainCnt_d = drainCnt_q + 2'd1;
                if (drainCnt_q == 2'd2) begin
                    state_d = REQ;
                end
            end
            REQ: state_d = OUT;
            OUT: begin
                outValid = 1'b1;
                if (bus.out_ready) begin
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACC;
            drainCnt_q  <= '0;
            prod_q      <= '0;
            prodValid_q <= 1'b0;
            acc_q       <= '0;
            firstBeat_q <= 1'b1;
            bias_q      <= '0;
            shift_q     <= '0;
            relu_q      <= 1'b0;
            outData_q   <= '0;
            outSat_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            drainCnt_q  <= drainCnt_d;
            prodValid_q <= accept;
            if (accept) begin
                prod_q <= {{(AW-2*DW){product[2*DW-1]}}, product};
            end
            if (prodValid_q) begin
                acc_q <= acc_q + prod_q;
            end
            if (accept && firstBeat_q) begin
                bias_q      <= bus.cfg_bias;
                shift_q     <= bus.cfg_shift;
                relu_q      <= bus.cfg_relu;
                firstBeat_q <= 1'b0;
            end
            if (state_q == REQ) begin
                outData_q <= satData;
                outSat_q  <= satFlag;
            end
            if (state_q == OUT && bus.out_ready) begin
                acc_q       <= '0;
                firstBeat_q <= 1'b1;
            end
        end
    end

    mac_requant_sat uSat (
        .acc_i   (acc_q),
        .bias_i  (bias_q),
        .shift_i (shift_q),
        .relu_i  (relu_q),
        .data_o  (satData),
        .sat_o   (satFlag)
    );

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid;
    assign bus.out_data  = outData_q;
    assign bus.out_sat   = outSat_q;

endmodule

// File: tb/tb_neuron_mac_requant.sv
// Scoreboard bench for neuron_mac_requant: expected results are queued as vectors are sent.
module tb_neuron_mac_requant;
    import neuron_mac_requant_pkg::*;

    typedef struct {
        logic signed [DW-1:0] a;
        logic signed [DW-1:0] b;
        int                   gap;
    } beat_t;

    typedef struct {
        logic signed [DW-1:0] data;
        logic                 sat;
    } res_t;

    logic clk;
    logic rst;
    int   passCount;
    int   checkCount;
    res_t sbQ[$];

    neuron_mac_requant_if bus();

    neuron_mac_requant dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic res_t model(input longint acc, input longint bias, input int shift, input bit relu);
        res_t   r;
        longint s;
        s = acc + bias;
        if (shift > 0) s = s + (longint'(1) << (shift - 1));
        s = s >>> shift;
        r.sat = 1'b0;
        if (s > 32767) begin
            s = 32767;
            r.sat = 1'b1;
        end else if (s < -32768) begin
            s = -32768;
            r.sat = 1'b1;
        end
        if (relu && s < 0) s = 0;
        r.data = DW'(s);
        return r;
    endfunction

    // Later beats carry random cfg values; only the first beat's cfg may be used.
    task automatic send_vector(input beat_t beats[$], input logic signed [AW-1:0] bias,
                               input logic [SW-1:0] shift, input logic relu, input bit withLast);
        int w;
        for (int i = 0; i < beats.size(); i++) begin
            for (int g = 0; g < beats[i].gap; g++) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                bus.in_a     = DW'($urandom);
                bus.in_b     = DW'($urandom);
                bus.in_last  = 1'($urandom);
            end
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_a     = beats[i].a;
            bus.in_b     = beats[i].b;
            bus.in_last  = withLast && (i == beats.size() - 1);
            if (i == 0) begin
                bus.cfg_bias  = bias;
                bus.cfg_shift = shift;
                bus.cfg_relu  = relu;
            end else begin
                bus.cfg_bias  = AW'({$urandom, $urandom});
                bus.cfg_shift = SW'($urandom);
                bus.cfg_relu  = 1'($urandom);
            end
            w = 0;
            while (!bus.in_ready && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (w == 20) begin
                checkCount++;
                $display("[TB] FAIL accept_timeout: in_ready stayed %0b, required 1", bus.in_ready);
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic collect(output res_t r, output int cycles, output bit ok);
        cycles = 0;
        @(negedge clk);
        while (!bus.out_valid && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
        ok     = bus.out_valid;
        r.data = bus.out_data;
        r.sat  = bus.out_sat;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic run_and_check(input string name, input beat_t beats[$], input logic signed [AW-1:0] bias,
                                 input logic [SW-1:0] shift, input logic relu, input res_t exp, input bit checkLat);
        res_t got;
        res_t want;
        int   cyc;
        bit   ok;
        sbQ.push_back(exp);
        send_vector(beats, bias, shift, relu, 1'b1);
        collect(got, cyc, ok);
        want = sbQ.pop_front();
        checkCount++;
        if (!ok) $display("[TB] FAIL %s_valid_timeout: out_valid=%0b, required 1", name, ok);
        else if (got.data !== want.data) $display("[TB] FAIL %s_data: got %0d, required %0d", name, got.data, want.data);
        else passCount++;
        checkCount++;
        if (got.sat !== want.sat) $display("[TB] FAIL %s_sat: got %0b, required %0b", name, got.sat, want.sat);
        else passCount++;
        if (checkLat) begin
            checkCount++;
            if (cyc !== 4) $display("[TB] FAIL %s_latency: got %0d cycles, required 4", name, cyc);
            else passCount++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkCount++;
        if (bus.in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %0b, required 1", bus.in_ready);
        else passCount++;
        checkCount++;
        if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %0b, required 0", bus.out_valid);
        else passCount++;
        checkCount++;
        if (bus.out_data !== 16'sd0) $display("[TB] FAIL reset_out_data: got %0d, required 0", bus.out_data);
        else passCount++;
        checkCount++;
        if (bus.out_sat !== 1'b0) $display("[TB] FAIL reset_out_sat: got %0b, required 0", bus.out_sat);
        else passCount++;
    endtask

    task automatic test_basic;
        beat_t v[$];
        res_t  e;
        v = '{'{16'sd2, 16'sd3, 0}, '{-16'sd4, 16'sd5, 0}, '{16'sd7, 16'sd1, 0}};
        e = '{-16'sd7, 1'b0};
        run_and_check("basic", v, '0, '0, 1'b0, e, 1'b1);
        e = '{16'sd0, 1'b0};
        run_and_check("basic_relu", v, '0, '0, 1'b1, e, 1'b1);
    endtask

    task automatic test_saturation;
        beat_t v[$];
        res_t  e;
        v = '{'{16'sd32767, 16'sd32767, 0}};
        e = '{16'sd32767, 1'b1};
        run_and_check("sat_pos", v, '0, '0, 1'b0, e, 1'b1);
        v = '{'{-16'sd32768, 16'sd32767, 0}};
        e = '{-16'sd32768, 1'b1};
        run_and_check("sat_neg", v, '0, '0, 1'b0, e, 1'b0);
    endtask

    task automatic test_rounding;
        beat_t v[$];
        res_t  e;
        v = '{'{16'sd2, 16'sd3, 0}};
        e = '{16'sd2, 1'b0};
        run_and_check("round_pos", v, '0, 5'd2, 1'b0, e, 1'b0);
        v = '{'{-16'sd2, 16'sd3, 0}};
        e = '{-16'sd1, 1'b0};
        run_and_check("round_neg", v, '0, 5'd2, 1'b0, e, 1'b0);
        v = '{'{16'sd1, 16'sd5, 0}};
        e = '{16'sd4, 1'b0};
        run_and_check("round_bias", v, 36'sd3, 5'd1, 1'b0, e, 1'b0);
    endtask

    task automatic test_backpressure;
        beat_t v[$];
        res_t  want;
        res_t  got;
        int    cyc;
        bit    stable;
        v = '{'{16'sd10, 16'sd10, 0}, '{-16'sd3, 16'sd4, 0}};
        sbQ.push_back('{16'sd88, 1'b0});
        send_vector(v, '0, '0, 1'b0, 1'b1);
        cyc = 0;
        @(negedge clk);
        while (!bus.out_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        got.data = bus.out_data;
        got.sat  = bus.out_sat;
        want = sbQ.pop_front();
        checkCount++;
        if (got.data !== want.data) $display("[TB] FAIL bp_data: got %0d, required %0d", got.data, want.data);
        else passCount++;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.out_data !== got.data || bus.out_sat !== got.sat || bus.in_ready !== 1'b0)
                stable = 1'b0;
        end
        checkCount++;
        if (stable !== 1'b1) $display("[TB] FAIL bp_hold: stable=%0b, required 1", stable);
        else passCount++;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        checkCount++;
        if (bus.in_ready !== 1'b1) $display("[TB] FAIL bp_in_ready_after: got %0b, required 1", bus.in_ready);
        else passCount++;
        bus.in_valid  = 1'b1;
        bus.in_a      = 16'sd1;
        bus.in_b      = 16'sd1;
        bus.in_last   = 1'b1;
        bus.cfg_bias  = '0;
        bus.cfg_shift = '0;
        bus.cfg_relu  = 1'b0;
        sbQ.push_back('{16'sd1, 1'b0});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        collect(got, cyc, stable);
        want = sbQ.pop_front();
        checkCount++;
        if (got.data !== want.data) $display("[TB] FAIL bp_next_data: got %0d, required %0d", got.data, want.data);
        else passCount++;
        checkCount++;
        if (cyc !== 4) $display("[TB] FAIL bp_next_latency: got %0d, required 4", cyc);
        else passCount++;
    endtask

    task automatic test_bubbles;
        beat_t                gapped[$];
        beat_t                packed_[$];
        beat_t                b;
        longint               acc;
        longint               biasL;
        int                   sh;
        bit                   relu;
        res_t                 e;
        for (int t = 0; t < 3; t++) begin
            gapped.delete();
            packed_.delete();
            acc = 0;
            for (int i = 0; i < 6; i++) begin
                b.a   = DW'(int'($urandom_range(0, 6000)) - 3000);
                b.b   = DW'(int'($urandom_range(0, 6000)) - 3000);
                b.gap = int'($urandom_range(0, 3));
                acc   = acc + longint'(b.a) * longint'(b.b);
                gapped.push_back(b);
                b.gap = 0;
                packed_.push_back(b);
            end
            biasL = longint'($urandom_range(0, 2097152)) - 1048576;
            sh    = (t == 0) ? 0 : int'($urandom_range(1, 20));
            relu  = 1'(t == 2);
            e     = model(acc, biasL, sh, relu);
            run_and_check("bubble_gapped", gapped, AW'(biasL), SW'(sh), relu, e, 1'b0);
            run_and_check("bubble_packed", packed_, AW'(biasL), SW'(sh), relu, e, 1'b0);
        end
    endtask

    task automatic test_reset_mid;
        beat_t v[$];
        res_t  e;
        bit    sawValid;
        v = '{'{16'sd100, 16'sd100, 0}, '{16'sd50, 16'sd7, 0}};
        send_vector(v, 36'sd999, 5'd3, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sawValid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) sawValid = 1'b1;
        end
        checkCount++;
        if (sawValid !== 1'b0) $display("[TB] FAIL rstmid_no_output: saw out_valid=%0b, required 0", sawValid);
        else passCount++;
        v = '{'{16'sd1, 16'sd1, 0}};
        e = '{16'sd1, 1'b0};
        run_and_check("rstmid_fresh", v, '0, '0, 1'b0, e, 1'b1);
    endtask

    initial begin
        passCount     = 0;
        checkCount    = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_last   = 1'b0;
        bus.cfg_bias  = '0;
        bus.cfg_shift = '0;
        bus.cfg_relu  = 1'b0;
        bus.out_ready = 1'b0;
        test_reset;
        test_basic;
        test_saturation;
        test_rounding;
        test_backpressure;
        test_bubbles;
        test_reset_mid;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
